// File: rtl/servo_pkg.sv
// Shared types and constants for the servo step sequencer.
package servo_pkg;

    localparam int ANGLE_W         = 3;
    localparam int ANGLE_MAX       = 4;
    localparam int CLK_HZ          = 50_000_000;
    localparam int STEP_CYCLES_DEF = CLK_HZ / 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter 0..STEP_CYCLES-1; tc flags the last count while enabled.
module dwell_timer #(
    parameter int STEP_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_step_sequencer.sv
// Rate-limited angle command front-end for the servo PWM driver.
// Build option SERVO_RAMP_EN: defined = one 45-degree step per dwell; undefined = jump, then dwell d periods.
module servo_step_sequencer #(
    parameter int STEP_CYCLES = servo_pkg::STEP_CYCLES_DEF,
    parameter int ANGLE_MAX   = servo_pkg::ANGLE_MAX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [servo_pkg::ANGLE_W-1:0] cmd_angle,
    output logic [servo_pkg::ANGLE_W-1:0] angle_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    import servo_pkg::*;

    localparam logic [ANGLE_W-1:0] AMAX = ANGLE_W'(ANGLE_MAX);

    state_t             state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               err_q, err_d;
    logic               tmr_clear;
    logic               tmr_en;
    logic               tmr_tc;
    logic               accept;

`ifdef SERVO_RAMP_EN
    logic [ANGLE_W-1:0] target_q, target_d;

    function automatic logic [ANGLE_W-1:0] step_toward(input logic [ANGLE_W-1:0] cur,
                                                       input logic [ANGLE_W-1:0] tgt);
        return (tgt > cur) ? cur + ANGLE_W'(1) : cur - ANGLE_W'(1);
    endfunction
`else
    // Dwell periods still owed after the current one.
    logic [ANGLE_W-1:0] steps_q, steps_d;

    function automatic logic [ANGLE_W-1:0] distance(input logic [ANGLE_W-1:0] a,
                                                    input logic [ANGLE_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction
`endif

    assign accept    = cmd_valid && (state_q == IDLE);
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign angle_idx = angle_q;

    dwell_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_dwell_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(tmr_clear),
        .en   (tmr_en),
        .tc   (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        err_d     = 1'b0;
        tmr_clear = 1'b0;
        tmr_en    = (state_q == DWELL);
`ifdef SERVO_RAMP_EN
        target_d  = target_q;
`else
        steps_d   = steps_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_angle > AMAX) begin
                        err_d = 1'b1;
                    end else if (cmd_angle == angle_q) begin
                        state_d = DONE;
                    end else begin
                        state_d   = DWELL;
                        tmr_clear = 1'b1;
`ifdef SERVO_RAMP_EN
                        target_d  = cmd_angle;
                        angle_d   = step_toward(angle_q, cmd_angle);
`else
                        angle_d   = cmd_angle;
                        steps_d   = distance(angle_q, cmd_angle) - ANGLE_W'(1);
`endif
                    end
                end
            end
            DWELL: begin
                if (tmr_tc) begin
`ifdef SERVO_RAMP_EN
                    if (angle_q == target_q) begin
                        state_d = DONE;
                    end else begin
                        angle_d = step_toward(angle_q, target_q);
                    end
`else
                    if (steps_q == '0) begin
                        state_d = DONE;
                    end else begin
                        steps_d = steps_q - ANGLE_W'(1);
                    end
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            angle_q  <= '0;
            err_q    <= 1'b0;
`ifdef SERVO_RAMP_EN
            target_q <= '0;
`else
            steps_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            angle_q  <= angle_d;
            err_q    <= err_d;
`ifdef SERVO_RAMP_EN
            target_q <= target_d;
`else
            steps_q  <= steps_d;
`endif
        end
    end

endmodule
